// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Five independent pushbutton channels. Each channel synchronises
//             its raw input, debounces it to a clean level, and emits one-cycle
//             strobes on press (and, optionally, auto-repeat while held).
//  Options  : define BTN_AUTOREPEAT_EN to compile in the DELAY/REPEAT hold
//             machine and its counter; otherwise a press gives exactly one
//             strobe and the RPT_* parameters have no effect.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  button_conditioner_chan : one synchroniser + debouncer + hold machine
// ----------------------------------------------------------------------------
module button_conditioner_chan #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int                 c_DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_deb;
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic               r_level;
    logic               r_pulse;
    logic               w_rise;
    logic               w_pulse_nxt;

    // Two-flop synchroniser; only the second stage feeds the debouncer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Debounce: count consecutive cycles of disagreement, flip the level at terminal count.
    // The counter stops at its terminal value (it clears on the flip), so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb     <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_sync == r_deb) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
            r_deb     <= ~r_deb;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    // The registered level lags the debouncer by one cycle, so the rising edge of the
    // debouncer is visible here and the press strobe lines up with the level going high.
    assign w_rise = r_deb & ~r_level;

`ifdef BTN_AUTOREPEAT_EN
    localparam int                  c_HOLD_TOP    = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int                  c_HOLD_W      = (c_HOLD_TOP > 1) ? $clog2(c_HOLD_TOP) : 1;
    localparam logic [c_HOLD_W-1:0] c_DELAY_LAST  = c_HOLD_W'(RPT_DELAY - 1);
    localparam logic [c_HOLD_W-1:0] c_PERIOD_LAST = c_HOLD_W'(RPT_PERIOD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_SAT    = '1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DELAY  = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_cnt_nxt;
    logic [c_HOLD_W-1:0] w_hold_cnt_inc;

    // Saturating increment of the hold counter.
    assign w_hold_cnt_inc = (r_hold_cnt == c_HOLD_SAT) ? r_hold_cnt : r_hold_cnt + 1'b1;

    // Hold-machine state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Hold machine: strobe on press, after the initial delay, then every period.
    // A released debounced level always returns to IDLE silently.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_pulse_nxt    = 1'b0;
        if (!r_deb) begin
            w_state_nxt    = c_ST_IDLE;
            w_hold_cnt_nxt = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_hold_cnt_nxt = '0;
                    if (w_rise) begin
                        w_state_nxt = c_ST_DELAY;
                        w_pulse_nxt = 1'b1;
                    end
                end
                c_ST_DELAY: begin
                    if (r_hold_cnt == c_DELAY_LAST) begin
                        w_state_nxt    = c_ST_REPEAT;
                        w_hold_cnt_nxt = '0;
                        w_pulse_nxt    = 1'b1;
                    end else begin
                        w_hold_cnt_nxt = w_hold_cnt_inc;
                    end
                end
                c_ST_REPEAT: begin
                    if (r_hold_cnt == c_PERIOD_LAST) begin
                        w_hold_cnt_nxt = '0;
                        w_pulse_nxt    = 1'b1;
                    end else begin
                        w_hold_cnt_nxt = w_hold_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt    = c_ST_IDLE;
                    w_hold_cnt_nxt = '0;
                end
            endcase
        end
    end
`else
    logic w_rpt_unused;

    // Without auto-repeat the strobe is just the press edge; the repeat timing
    // parameters are tied off here so they are visibly intentionally unused.
    assign w_pulse_nxt  = w_rise;
    assign w_rpt_unused = (RPT_DELAY > 0) ^ (RPT_PERIOD > 0);
`endif

    // Output registers: debounced level and one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_level <= r_deb;
            r_pulse <= w_pulse_nxt;
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// ----------------------------------------------------------------------------
//  button_conditioner : five identical channels, {btnD,btnR,btnL,btnU,btnC}
// ----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse
);

    localparam int c_NUM_BTN = 5;

    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_BTN; gi++) begin : g_chan
            button_conditioner_chan #(
                .DEB_CYCLES (DEB_CYCLES),
                .RPT_DELAY  (RPT_DELAY),
                .RPT_PERIOD (RPT_PERIOD)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_raw   (btn_raw[gi]),
                .o_level (btn_level[gi]),
                .o_pulse (btn_pulse[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Self-checking bench for button_conditioner with short timing
//             (DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=5). Expected strobes are
//             queued per scenario and compared every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = DEB + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_raw = 5'b0;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    typedef struct {
        int         e;
        logic [4:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    button_conditioner #(
        .DEB_CYCLES (DEB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the number of the edge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int e, input logic [4:0] v);
        exp_t t;
        t.e = e;
        t.v = v;
        sb.push_back(t);
    endtask

    // Queue the strobes of one hold: press = first edge of the final stable run,
    // rel = first edge sampling the release.
    task automatic plan_hold(input int base, input int press, input int rel, input logic [4:0] m);
        push_exp(base + press + LAT, m);
`ifdef BTN_AUTOREPEAT_EN
        for (int e = press + LAT + RD; e <= rel + LAT - 1; e += RP)
            push_exp(base + e, m);
`endif
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = 5'b11111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== 5'b0) begin errors++; $display("FAIL reset_level got=%b exp=%b", btn_level, 5'b0); end
            checks++;
            if (btn_pulse !== 5'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=%b", btn_pulse, 5'b0); end
        end
        btn_raw = 5'b0;
        rst_n   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (btn_level !== 5'b0) begin errors++; $display("FAIL post_reset_level got=%b exp=%b", btn_level, 5'b0); end
            checks++;
            if (btn_pulse !== 5'b0) begin errors++; $display("FAIL post_reset_pulse got=%b exp=%b", btn_pulse, 5'b0); end
        end
    endtask

    task automatic test_clean_press();
        int base, r;
        logic [4:0] exp_p, exp_l;
        @(negedge clk);
        base = cyc + 1;
        plan_hold(base, 0, 15, 5'b00001);
        btn_raw = 5'b00001;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            r = cyc - base;
            exp_p = 5'b0;
            while (sb.size() > 0 && sb[0].e == cyc) begin exp_p |= sb[0].v; sb.delete(0); end
            exp_l = (r >= LAT && r < 15 + LAT) ? 5'b00001 : 5'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL clean_pulse rel=%0d got=%b exp=%b", r, btn_pulse, exp_p); end
            checks++;
            if (btn_level !== exp_l) begin errors++; $display("FAIL clean_level rel=%0d got=%b exp=%b", r, btn_level, exp_l); end
            btn_raw = (r + 1 < 15) ? 5'b00001 : 5'b0;
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL clean_missed got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    // btnL high for DEB-1 cycles (rejected), btnR high for exactly DEB cycles (accepted).
    task automatic test_glitch();
        int base, r;
        logic [4:0] exp_p, exp_l;
        @(negedge clk);
        base = cyc + 1;
        plan_hold(base, 0, 4, 5'b01000);
        btn_raw = 5'b01100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            r = cyc - base;
            exp_p = 5'b0;
            while (sb.size() > 0 && sb[0].e == cyc) begin exp_p |= sb[0].v; sb.delete(0); end
            exp_l = (r >= LAT && r < 4 + LAT) ? 5'b01000 : 5'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL glitch_pulse rel=%0d got=%b exp=%b", r, btn_pulse, exp_p); end
            checks++;
            if (btn_level !== exp_l) begin errors++; $display("FAIL glitch_level rel=%0d got=%b exp=%b", r, btn_level, exp_l); end
            btn_raw = {1'b0, (r + 1 < 4), (r + 1 < 3), 2'b00};
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL glitch_missed got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    // btnU samples 1,0,1,0 then stays 1 from rel 4 until release at rel 20.
    task automatic test_bounce();
        int base, r, nr;
        logic [4:0] exp_p, exp_l;
        @(negedge clk);
        base = cyc + 1;
        plan_hold(base, 4, 20, 5'b00010);
        btn_raw = 5'b00010;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            r = cyc - base;
            exp_p = 5'b0;
            while (sb.size() > 0 && sb[0].e == cyc) begin exp_p |= sb[0].v; sb.delete(0); end
            exp_l = (r >= 4 + LAT && r < 20 + LAT) ? 5'b00010 : 5'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL bounce_pulse rel=%0d got=%b exp=%b", r, btn_pulse, exp_p); end
            checks++;
            if (btn_level !== exp_l) begin errors++; $display("FAIL bounce_level rel=%0d got=%b exp=%b", r, btn_level, exp_l); end
            nr = r + 1;
            btn_raw = (nr == 2 || (nr >= 4 && nr < 20)) ? 5'b00010 : 5'b0;
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL bounce_missed got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    // btnL held for 40 cycles.
    task automatic test_autorepeat();
        int base, r;
        logic [4:0] exp_p, exp_l;
        @(negedge clk);
        base = cyc + 1;
        plan_hold(base, 0, 40, 5'b00100);
        btn_raw = 5'b00100;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            r = cyc - base;
            exp_p = 5'b0;
            while (sb.size() > 0 && sb[0].e == cyc) begin exp_p |= sb[0].v; sb.delete(0); end
            exp_l = (r >= LAT && r < 40 + LAT) ? 5'b00100 : 5'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL repeat_pulse rel=%0d got=%b exp=%b", r, btn_pulse, exp_p); end
            checks++;
            if (btn_level !== exp_l) begin errors++; $display("FAIL repeat_level rel=%0d got=%b exp=%b", r, btn_level, exp_l); end
            btn_raw = (r + 1 < 40) ? 5'b00100 : 5'b0;
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL repeat_missed got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    // btnR and btnD pressed on the same edge.
    task automatic test_simultaneous();
        int base, r;
        logic [4:0] exp_p, exp_l;
        @(negedge clk);
        base = cyc + 1;
        plan_hold(base, 0, 10, 5'b11000);
        btn_raw = 5'b11000;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            r = cyc - base;
            exp_p = 5'b0;
            while (sb.size() > 0 && sb[0].e == cyc) begin exp_p |= sb[0].v; sb.delete(0); end
            exp_l = (r >= LAT && r < 10 + LAT) ? 5'b11000 : 5'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL simul_pulse rel=%0d got=%b exp=%b", r, btn_pulse, exp_p); end
            checks++;
            if (btn_level !== exp_l) begin errors++; $display("FAIL simul_level rel=%0d got=%b exp=%b", r, btn_level, exp_l); end
            btn_raw = (r + 1 < 10) ? 5'b11000 : 5'b0;
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL simul_missed got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    // btnC held; reset asserted mid-cycle after edge 30, released after edge 35.
    task automatic test_reset_mid_hold();
        int base, r;
        logic [4:0] exp_p, exp_l;
        @(negedge clk);
        base = cyc + 1;
        push_exp(base + LAT, 5'b00001);
`ifdef BTN_AUTOREPEAT_EN
        push_exp(base + LAT + RD, 5'b00001);
`endif
        push_exp(base + 36 + LAT, 5'b00001);
        btn_raw = 5'b00001;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            r = cyc - base;
            exp_p = 5'b0;
            while (sb.size() > 0 && sb[0].e == cyc) begin exp_p |= sb[0].v; sb.delete(0); end
            exp_l = ((r >= LAT && r <= 30) || (r >= 36 + LAT && r < 55 + LAT)) ? 5'b00001 : 5'b0;
            checks++;
            if (btn_pulse !== exp_p) begin errors++; $display("FAIL rstmid_pulse rel=%0d got=%b exp=%b", r, btn_pulse, exp_p); end
            checks++;
            if (btn_level !== exp_l) begin errors++; $display("FAIL rstmid_level rel=%0d got=%b exp=%b", r, btn_level, exp_l); end
            btn_raw = (r + 1 < 55) ? 5'b00001 : 5'b0;
            if (r == 30) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (btn_level !== 5'b0) begin errors++; $display("FAIL rstmid_async_level got=%b exp=%b", btn_level, 5'b0); end
                checks++;
                if (btn_pulse !== 5'b0) begin errors++; $display("FAIL rstmid_async_pulse got=%b exp=%b", btn_pulse, 5'b0); end
            end
            if (r == 35) rst_n = 1'b1;
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL rstmid_missed got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_autorepeat();
        test_simultaneous();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 1_000_000, sets the stable-level cycles needed to accept a change (10 ms at 100 MHz).
REQ-002 Parameter RPT_DELAY, default 50_000_000, sets the hold cycles before the first auto-repeat pulse (500 ms).
REQ-003 Parameter RPT_PERIOD, default 10_000_000, sets the cycles between later auto-repeat pulses (100 ms).
REQ-004 The block SHALL run on one clock, with an asynchronous, active-low reset.
REQ-005 Port clk, input, 1 bit: 100 MHz system clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port btn_raw, input, 5 bits: raw pushbuttons, bit order {btnD,btnR,btnL,btnU,btnC}, asynchronous and bouncing.
REQ-008 Port btn_level, output, 5 bits: debounced level for each button.
REQ-009 Port btn_pulse, output, 5 bits: one-cycle press and repeat strobes, which feed the clock's time-set inputs downstream.

Function
REQ-010 Each bit SHALL be processed independently by an identical channel, with no interaction between bits.
REQ-011 Each channel SHALL pass btn_raw through a 2-flop synchronizer; only the second flop output (sync) is used.
REQ-012 Debounce counter: cleared when sync equals btn_level; incremented each cycle while they differ.
REQ-013 When the counter reaches DEB_CYCLES-1 with sync still differing, btn_level SHALL toggle on the next edge and the counter SHALL clear.
REQ-014 A clean 0->1 raw step SHALL produce btn_level high exactly DEB_CYCLES+2 edges after the first edge that samples it.
REQ-015 Any bounce (sync returning to btn_level) before terminal count SHALL clear the counter; btn_level does not change and no pulse is produced.
REQ-016 Each channel SHALL have a hold FSM with states IDLE, DELAY and REPEAT.
REQ-017 IDLE -> DELAY on btn_level 0->1; btn_pulse is high for exactly the one cycle in which btn_level first reads 1.
REQ-018 DELAY: the hold counter counts up; at RPT_DELAY-1, go to REPEAT with a one-cycle pulse and clear the counter.
REQ-019 REPEAT: a one-cycle pulse every RPT_PERIOD cycles while btn_level stays 1.
REQ-020 A btn_level 1->0 transition from any state SHALL go to IDLE, clear the hold counter, and produce no pulse; releasing never pulses.
REQ-021 Counter widths SHALL be $clog2 of their terminal value; counters saturate and never wrap.
REQ-022 Simultaneous presses on several bits SHALL yield simultaneous pulses on the corresponding btn_pulse bits.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately clear the synchronizers, counters, btn_level and btn_pulse, and force IDLE, whatever the current state.
REQ-024 After reset is released with a button already held, that button SHALL debounce as a fresh press (pulse after DEB_CYCLES+2 edges).
REQ-025 Asserting reset mid-repeat SHALL drop btn_pulse and btn_level within the same cycle, with no glitch pulse on release.

Configuration
REQ-026 Macro BTN_AUTOREPEAT_EN, when defined, SHALL compile in the DELAY/REPEAT states and the hold counter.
REQ-027 Without BTN_AUTOREPEAT_EN, the FSM SHALL reduce to press-edge detect: exactly one pulse per press, and RPT_* are unused.

Verification (DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=5)
REQ-028 Clean btnC press at edge 0 -> btn_level[0]=1 and btn_pulse[0]=1 at edge 6; the pulse lasts one cycle.
REQ-029 btnU bouncing 1,0,1,0 over 3 cycles then stable 1 -> exactly one pulse, 6 edges after the last bounce.
REQ-030 btnL held for 40 cycles with BTN_AUTOREPEAT_EN -> pulses at press+6, +26, +31, +36, +41; none after release.
REQ-031 btnR and btnD pressed on the same edge -> btn_pulse=5'b11000 for one cycle.
REQ-032 rst_n asserted at cycle 30 of a btnC hold, released at 35 with the button still held -> outputs 0 during reset, fresh pulse 6 edges after release.
REQ-033 Same hold as REQ-030 without BTN_AUTOREPEAT_EN -> a single pulse at press+6 only.
